// File: rtl/ticket_pkg.sv
// Shared state encoding and helper functions for the multi-destination ticket vendor.
package ticket_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    COLLECT  = 2'd1,
    DISPENSE = 2'd2,
    CHANGE   = 2'd3
  } state_t;

  localparam int MAXW = 32;
  localparam int PT_W = 256;

  typedef struct packed {
    logic       vld;
    logic [4:0] idx;
  } onehot_t;

  // Fare of destination idx from a packed table of pw-bit slices, dest0 in the LSBs.
  function automatic logic [MAXW-1:0] fare_of(input logic [PT_W-1:0] prices, input int idx,
                                              input int pw);
    logic [PT_W-1:0] sh;
    logic [63:0]     mask;
    sh   = prices >> (idx * pw);
    mask = (64'd1 << pw) - 64'd1;
    return sh[MAXW-1:0] & mask[MAXW-1:0];
  endfunction

  function automatic onehot_t onehot_idx(input logic [MAXW-1:0] sel, input int n);
    onehot_t         r;
    int              cnt;
    logic [MAXW-1:0] tmp;
    r   = '0;
    cnt = 0;
    for (int i = 0; i < MAXW; i++) begin
      tmp = sel >> i;
      if (i < n && tmp[0]) begin
        cnt++;
        r.idx = 5'(i);
      end
    end
    r.vld = (cnt == 1);
    return r;
  endfunction

  function automatic logic [MAXW-1:0] min_chg(input logic [MAXW-1:0] rem, input int cw);
    logic [MAXW-1:0] cap;
    cap = MAXW'((64'd1 << cw) - 64'd1);
    return (rem < cap) ? rem : cap;
  endfunction

endpackage

// File: rtl/ticket_change_unit.sv
// Change/refund down-counter: emits at most 2^CHANGE_W-1 per cycle until the loaded amount is paid out.
module ticket_change_unit
  import ticket_pkg::*;
#(
  parameter int CREDIT_W = 6,
  parameter int CHANGE_W = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic                step,
  input  logic [CREDIT_W-1:0] load_val,
  output logic [CHANGE_W-1:0] change,
  output logic                change_valid,
  output logic                done
);

  logic [CREDIT_W-1:0] rem_q;
  logic [CREDIT_W-1:0] src;
  logic [CREDIT_W-1:0] chunk;

  // The first chunk goes out on the load edge so change follows the ticket/cancel cycle directly.
  always_comb begin
    src   = load ? load_val : rem_q;
    chunk = CREDIT_W'(min_chg(MAXW'(src), CHANGE_W));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q        <= '0;
      change       <= '0;
      change_valid <= 1'b0;
    end else if (load || (step && rem_q != '0)) begin
      change       <= CHANGE_W'(chunk);
      change_valid <= (chunk != '0);
      rem_q        <= src - chunk;
    end else begin
      change       <= '0;
      change_valid <= 1'b0;
    end
  end

  assign done = (rem_q == '0);

endmodule

// File: rtl/ticket_vend_multi.sv
// Multi-destination ticket vending FSM: fare lock, coin credit, ticket pulse, change/refund payout.
module ticket_vend_multi
  import ticket_pkg::*;
#(
  parameter int                         N_DEST   = 4,
  parameter int                         COIN_W   = 3,
  parameter int                         PRICE_W  = 5,
  parameter logic [N_DEST*PRICE_W-1:0]  PRICES   = {5'd15, 5'd12, 5'd10, 5'd6},
  parameter int                         CREDIT_W = 6,
  parameter int                         CHANGE_W = 3,
  localparam int                        DEST_W   = (N_DEST > 1) ? $clog2(N_DEST) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_DEST-1:0]   sel,
  input  logic [COIN_W-1:0]   coin,
  input  logic                cancel,
  output logic                ticket,
  output logic [DEST_W-1:0]   dest_out,
  output logic [CHANGE_W-1:0] change,
  output logic                change_valid,
  output logic                coin_reject,
  output logic                busy,
  output logic [CREDIT_W-1:0] credit,
  output logic [1:0]          state
);

  state_t              state_q, state_n;
  logic [DEST_W-1:0]   dest_q, dest_n;
  logic [PRICE_W-1:0]  fare_q, fare_n;
  logic [CREDIT_W-1:0] credit_n;
  logic [CREDIT_W:0]   sum;
  logic [CREDIT_W-1:0] sum_sat;
  logic                load;
  logic [CREDIT_W-1:0] load_val;
  logic                chg_done;
  onehot_t             oh;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_n;
  end

  always_comb begin
    state_n  = state_q;
    dest_n   = dest_q;
    fare_n   = fare_q;
    credit_n = credit;
    load     = 1'b0;
    load_val = '0;
    oh       = onehot_idx(MAXW'(sel), N_DEST);
    sum      = {1'b0, credit} + (CREDIT_W + 1)'(coin);
    sum_sat  = sum[CREDIT_W] ? '1 : sum[CREDIT_W-1:0];
    case (state_q)
      IDLE: begin
        credit_n = '0;
        if (oh.vld) begin
          dest_n  = DEST_W'(oh.idx);
          fare_n  = PRICE_W'(fare_of(PT_W'(PRICES), int'(oh.idx), PRICE_W));
          state_n = COLLECT;
        end
      end
      COLLECT: begin
        // The coin arriving with cancel is still accepted and refunded with the rest.
        if (cancel) begin
          load     = 1'b1;
          load_val = sum_sat;
          credit_n = '0;
          state_n  = CHANGE;
        end else begin
          credit_n = sum_sat;
          if (sum_sat >= CREDIT_W'(fare_q)) state_n = DISPENSE;
        end
      end
      DISPENSE: begin
        credit_n = '0;
        load_val = credit - CREDIT_W'(fare_q);
        if (load_val != '0) begin
          load    = 1'b1;
          state_n = CHANGE;
        end else begin
          state_n = IDLE;
        end
      end
      CHANGE: begin
        if (chg_done) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dest_q      <= '0;
      fare_q      <= '0;
      credit      <= '0;
      ticket      <= 1'b0;
      dest_out    <= '0;
      coin_reject <= 1'b0;
      busy        <= 1'b0;
    end else begin
      dest_q      <= dest_n;
      fare_q      <= fare_n;
      credit      <= credit_n;
      ticket      <= (state_n == DISPENSE);
      dest_out    <= (state_n == DISPENSE) ? dest_n : '0;
      coin_reject <= (coin != '0) && (state_q != COLLECT);
      busy        <= (state_n != IDLE);
    end
  end

  assign state = state_q;

  ticket_change_unit #(
    .CREDIT_W(CREDIT_W),
    .CHANGE_W(CHANGE_W)
  ) u_chg (
    .clk         (clk),
    .rst         (rst),
    .load        (load),
    .step        (state_q == CHANGE),
    .load_val    (load_val),
    .change      (change),
    .change_valid(change_valid),
    .done        (chg_done)
  );

endmodule

// File: doc/ticket_vend_multi.md
Name: ticket_vend_multi

Overview:
- Parametrised multi-destination ticket vending controller; successor to the three-selection fixed-fare ticket FSM.
- Handles N_DEST destinations with per-destination fares and accumulates coin credit.
- Issues a one-cycle ticket pulse with the destination index.
- Returns change, or a full refund on cancel, over as many cycles as needed, limited per cycle by CHANGE_W.
- Sits between the coin acceptor and the ticket printer / coin hopper.

Parameters:
- N_DEST, 4: number of destinations / selection lines.
- COIN_W, 3: width of coin value input; 0 means no coin.
- PRICE_W, 5: width of one fare.
- PRICES, {5'd15,5'd12,5'd10,5'd6}: packed fare table, N_DEST*PRICE_W bits; slice i is the fare of destination i (dest0 = LSBs = 6).
- CREDIT_W, 6: credit accumulator width; must satisfy 2^CREDIT_W-1 >= max fare + 2^COIN_W-1.
- CHANGE_W, 3: max coin value the hopper returns per cycle is 2^CHANGE_W-1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- sel  in  N_DEST  one-hot destination select.
- coin  in  COIN_W  coin value inserted this cycle.
- cancel  in  1  abort purchase and refund.
- ticket  out  1  one-cycle ticket issue pulse.
- dest_out  out  clog2(N_DEST)  destination index, valid while ticket=1, else 0.
- change  out  CHANGE_W  value returned this cycle.
- change_valid  out  1  change holds a nonzero return.
- coin_reject  out  1  pulse: coin presented when not accepted.
- busy  out  1  high in every state except IDLE.
- credit  out  CREDIT_W  current accumulated credit.
- state  out  2  current FSM state, for debug.

Behaviour:
- All outputs are registered. Reset is asynchronous and applies at any time, including mid-transaction:
  - state = IDLE;
  - credit, remaining, dest register = 0;
  - all outputs = 0;
  - any in-flight credit is discarded.
- State encoding: IDLE=0, COLLECT=1, DISPENSE=2, CHANGE=3.
- IDLE:
  - credit = 0.
  - If sel has exactly one bit set: latch dest index and fare, go to COLLECT.
  - sel = 0 or multi-hot: ignored, stay in IDLE.
  - A nonzero coin in IDLE is not credited; coin_reject pulses on the next cycle.
  - cancel in IDLE: no effect.
- COLLECT:
  - credit_n = credit + coin.
  - If cancel=1: remaining = credit_n, go to CHANGE (refund, no ticket). cancel has priority over fare completion in the same cycle.
  - Else if credit_n >= fare: credit = credit_n, go to DISPENSE.
  - Else: credit = credit_n, stay in COLLECT.
  - sel changes in COLLECT are ignored; the fare is locked.
- DISPENSE (exactly one cycle):
  - ticket = 1 and dest_out = latched index.
  - remaining = credit - fare.
  - If remaining > 0, go to CHANGE; else go to IDLE.
  - credit clears on the exit cycle.
- CHANGE:
  - Each cycle: change = min(remaining, 2^CHANGE_W-1), change_valid = 1, remaining -= change.
  - Go to IDLE in the same cycle the last nonzero change is output.
  - The total of all change outputs equals the overpay or the refund exactly.
- Coins in DISPENSE or CHANGE are not credited; coin_reject pulses. cancel is ignored in DISPENSE and CHANGE.
- Latency:
  - Ticket pulse occurs one cycle after the edge that samples the completing coin.
  - First change output occurs in the cycle after the ticket pulse, or in the cycle after the cancel sample.
- Width rules: credit addition saturates at 2^CREDIT_W-1 (unreachable when parameters are legal); subtraction is unsigned and never negative by construction.

Decomposition:
- Package ticket_pkg holds:
  - state encodings;
  - function fare_of(idx), which slices PRICES;
  - function onehot_idx(sel) with a valid flag;
  - function min_chg(remaining).
- Sub-module ticket_change_unit: load/remaining down-counter producing change/change_valid and a done flag. The main FSM instantiates it once.

Test Plan:
- Exact fare: rst then release; sel=0001; coins 2,2,2 on successive cycles -> ticket=1 with dest_out=0 one cycle after the third coin; no change_valid; back to IDLE with credit=0.
- Overpay: sel=0010 (fare 10); coins 5,7 -> credit 12 -> ticket with dest_out=1; next cycle change=2, change_valid=1; then IDLE.
- Multi-cycle refund: sel=1000 (fare 15); coins 7,7; then cancel=1 with coin=0 -> no ticket; change=7 then change=7 on two consecutive cycles; then IDLE.
- Cancel vs completion: sel=0001 (fare 6); coin=7 with cancel=1 in the same cycle -> no ticket; refund change=7 in one cycle.
- Rejects and ignored selects:
  - coin=5 while IDLE -> coin_reject pulse, credit stays 0;
  - sel=0110 -> remains IDLE, busy=0;
  - coin=3 during CHANGE -> coin_reject, change total unaffected.
- Reset mid-operation: rst=1 during CHANGE with remaining 7 -> all outputs 0 immediately (asynchronous); IDLE after release; next purchase behaves normally.
